// File: rtl/reg_lock_sched.sv
// Register-lock issue scheduler: grants one of NP requesters whose operands and destination are free.
// Latency: grant is combinational from registered state; lock/busy/FSM updates land on the next edge.
// Backpressure: a requester simply sees gnt_o low while its hazards persist; it must hold its request.
module reg_lock_sched #(
  parameter int NR = 32,
  parameter int NP = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NP-1:0]              req_valid_i,
  input  logic [NP-1:0]              req_blocking_i,
  input  logic [NP-1:0]              req_mem_op_i,
  input  logic [NP*$clog2(NR)-1:0]   req_rd_i,
  input  logic [NP*NR-1:0]           req_src_i,
  output logic [NP-1:0]              gnt_o,
  input  logic                       wb_valid_i,
  input  logic [$clog2(NR)-1:0]      wb_rd_i,
  input  logic                       mem_done_i,
  input  logic                       blk_done_i,
  output logic [NR-1:0]              locks_o,
  output logic                       mem_busy_o,
  output logic                       blocked_o
);

  localparam int RW = $clog2(NR);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [NR-1:0] BIT0 = NR'(1);

  typedef enum logic {RUN = 1'b0, BLOCKED = 1'b1} state_t;

  state_t          state_q;
  logic [NR-1:0]   locks_q;
  logic            mem_busy_q;
  logic [PW-1:0]   rr_ptr;

  logic [NP-1:0]   elig;
  logic [RW-1:0]   rd_arr [NP];
  logic [NP-1:0]   gnt;
  logic            any_gnt;
  logic [PW-1:0]   gidx;
  logic [RW-1:0]   g_rd;
  logic            g_mem;
  logic            g_blk;
  logic [NR-1:0]   set_vec;
  logic [NR-1:0]   clr_vec;
  logic [NR-1:0]   locks_d;
  logic [PW-1:0]   rr_next;

  // Per-requester hazard check, using only registered state so a same-cycle release never bypasses.
  genvar p;
  generate
    for (p = 0; p < NP; p++) begin : g_elig
      logic [NR-1:0] src;
      logic          src_free;
      logic          rd_free;
      logic          mem_ok;
      logic          blk_ok;
      assign rd_arr[p] = req_rd_i[p*RW +: RW];
      assign src       = req_src_i[p*NR +: NR];
      // Bit 0 of the source mask is the zero register and never a hazard.
      assign src_free  = ((src & locks_q & ~BIT0) == '0);
      assign rd_free   = (rd_arr[p] == '0) || !locks_q[rd_arr[p]];
      assign mem_ok    = !req_mem_op_i[p] || !mem_busy_q;
      // Blocking instructions need the whole machine quiet before they go.
      assign blk_ok    = !req_blocking_i[p] || ((locks_q == '0) && !mem_busy_q);
      assign elig[p]   = (state_q == RUN) && req_valid_i[p] && src_free && rd_free && mem_ok && blk_ok;
    end
  endgenerate

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    any_gnt = 1'b0;
    gidx    = '0;
    gnt     = '0;
    for (int i = 0; i < NP; i++) begin
      cand = (int'(rr_ptr) + i) % NP;
      if (!any_gnt && elig[cand]) begin
        any_gnt = 1'b1;
        gidx    = PW'(cand);
      end
    end
    if (any_gnt) gnt[gidx] = 1'b1;
  end

  assign g_rd  = rd_arr[gidx];
  assign g_mem = any_gnt && req_mem_op_i[gidx];
  assign g_blk = any_gnt && req_blocking_i[gidx];

  // Next lock vector: writeback clears, grant sets, set wins on a collision, register 0 never locks.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (any_gnt && (g_rd != '0)) set_vec[g_rd] = 1'b1;
    if (wb_valid_i && (wb_rd_i != '0)) clr_vec[wb_rd_i] = 1'b1;
    locks_d    = (locks_q & ~clr_vec) | set_vec;
    locks_d[0] = 1'b0;
  end

  assign rr_next = (gidx == PW'(NP - 1)) ? '0 : gidx + 1'b1;

  // All scheduler state and the RUN/BLOCKED FSM; reset drops any outstanding work on the floor.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      locks_q    <= '0;
      mem_busy_q <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      locks_q <= locks_d;
      if (g_mem)           mem_busy_q <= 1'b1;
      else if (mem_done_i) mem_busy_q <= 1'b0;
      if (any_gnt) rr_ptr <= rr_next;
      case (state_q)
        RUN:     if (g_blk)      state_q <= BLOCKED;
        BLOCKED: if (blk_done_i) state_q <= RUN;
        default:                 state_q <= RUN;
      endcase
    end
  end

  // Grant is suppressed while reset is held so nothing downstream acts on it.
  assign gnt_o      = rst_ni ? gnt : '0;
  assign locks_o    = locks_q;
  assign mem_busy_o = mem_busy_q;
  assign blocked_o  = (state_q == BLOCKED);

endmodule

// File: tb/tb_reg_lock_sched.sv
// Bench for reg_lock_sched: directed hazard scenarios, then a randomized run against a reference model.
// Expectations are queued by the driver; a negedge monitor pops and compares every queued cycle.
// Inputs are driven #1 after the rising edge.
module tb_reg_lock_sched;
  localparam int NR = 32;
  localparam int NP = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   valid, blocking, mem_op;
  logic [19:0]  rd_bus;
  logic [127:0] src_bus;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic         mem_done, blk_done;
  logic [3:0]   gnt;
  logic [31:0]  locks;
  logic         mem_busy, blocked;

  always #5 clk = ~clk;

  reg_lock_sched #(.NR(NR), .NP(NP)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_blocking_i(blocking), .req_mem_op_i(mem_op),
    .req_rd_i(rd_bus), .req_src_i(src_bus),
    .gnt_o(gnt),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .mem_done_i(mem_done), .blk_done_i(blk_done),
    .locks_o(locks), .mem_busy_o(mem_busy), .blocked_o(blocked)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] locks;
    logic        busy;
    logic        blocked;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [31:0] m_locks;
  logic        m_busy, m_blk;
  int          m_rr;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "gnt",      32'(gnt),      32'(e.gnt));
      chk(nm, "locks",    locks,         e.locks);
      chk(nm, "mem_busy", 32'(mem_busy), 32'(e.busy));
      chk(nm, "blocked",  32'(blocked),  32'(e.blocked));
    end
  end

  function automatic logic [31:0] bm(input int i);
    return 32'h1 << i;
  endfunction

  task automatic idle();
    valid = '0; blocking = '0; mem_op = '0; rd_bus = '0; src_bus = '0;
    wb_valid = 1'b0; wb_rd = '0; mem_done = 1'b0; blk_done = 1'b0;
  endtask

  task automatic req(input int p, input logic b, input logic m, input int rd, input logic [31:0] src);
    logic [4:0] r;
    r = rd[4:0];
    valid[p] = 1'b1; blocking[p] = b; mem_op[p] = m;
    rd_bus[p*5 +: 5] = r;
    src_bus[p*32 +: 32] = src;
  endtask

  // Queue what this cycle must show, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic [3:0] g, input logic [31:0] l, input logic b, input logic bl);
    exp_t e;
    e.gnt = g; e.locks = l; e.busy = b; e.blocked = bl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    valid = 4'hF;
    @(posedge clk); #1;
    cyc("reset", 4'b0000, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Round-robin across four free requesters, each locking its destination.
    idle();
    req(0, 0, 0, 5, 0); req(1, 0, 0, 6, 0); req(2, 0, 0, 7, 0); req(3, 0, 0, 8, 0);
    cyc("rr0", 4'b0001, 32'h0, 0, 0);
    cyc("rr1", 4'b0010, bm(5), 0, 0);
    cyc("rr2", 4'b0100, bm(5) | bm(6), 0, 0);
    cyc("rr3", 4'b1000, bm(5) | bm(6) | bm(7), 0, 0);
    cyc("rd_all_locked", 4'b0000, bm(5) | bm(6) | bm(7) | bm(8), 0, 0);
    idle(); wb_valid = 1'b1; wb_rd = 5'd6;
    cyc("wb6", 4'b0000, bm(5) | bm(6) | bm(7) | bm(8), 0, 0);
    wb_rd = 5'd7;
    cyc("wb7", 4'b0000, bm(5) | bm(7) | bm(8), 0, 0);
    wb_rd = 5'd8;
    cyc("wb8", 4'b0000, bm(5) | bm(8), 0, 0);
    idle();
    cyc("hold5", 4'b0000, bm(5), 0, 0);

    // Source hazard released by writeback only takes effect the following cycle.
    req(0, 0, 0, 0, bm(5));
    cyc("src_locked", 4'b0000, bm(5), 0, 0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    cyc("wb_no_bypass", 4'b0000, bm(5), 0, 0);
    wb_valid = 1'b0;
    cyc("wb_then_grant", 4'b0001, 32'h0, 0, 0);
    idle();
    cyc("rd0_no_lock", 4'b0000, 32'h0, 0, 0);

    // Memory ops serialize on mem_busy.
    req(1, 0, 1, 0, 0); req(2, 0, 1, 0, 0);
    cyc("mem1", 4'b0010, 32'h0, 0, 0);
    valid[1] = 1'b0;
    cyc("mem2_held", 4'b0000, 32'h0, 1, 0);
    mem_done = 1'b1;
    cyc("mem_done_no_bypass", 4'b0000, 32'h0, 1, 0);
    mem_done = 1'b0;
    cyc("mem2_grant", 4'b0100, 32'h0, 0, 0);
    idle(); mem_done = 1'b1;
    cyc("mem_busy_again", 4'b0000, 32'h0, 1, 0);
    idle();
    cyc("mem_idle", 4'b0000, 32'h0, 0, 0);

    // Blocking instruction stalls all issue until blk_done; blk_done in RUN is ignored.
    req(3, 1, 0, 0, 0); blk_done = 1'b1;
    cyc("blk_grant", 4'b1000, 32'h0, 0, 0);
    idle(); valid = 4'hF;
    for (int i = 0; i < 10; i++) cyc("blocked_hold", 4'b0000, 32'h0, 0, 1);
    blk_done = 1'b1;
    cyc("blk_done", 4'b0000, 32'h0, 0, 1);
    blk_done = 1'b0;
    cyc("resume0", 4'b0001, 32'h0, 0, 0);
    cyc("resume1", 4'b0010, 32'h0, 0, 0);

    // Set beats clear on the same index; a held lock keeps a blocking request out.
    idle(); req(2, 0, 0, 9, 0); wb_valid = 1'b1; wb_rd = 5'd9;
    cyc("set_wins", 4'b0100, 32'h0, 0, 0);
    idle();
    cyc("lock9", 4'b0000, bm(9), 0, 0);
    req(3, 1, 0, 0, 0);
    cyc("blk_lock_held", 4'b0000, bm(9), 0, 0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    cyc("blk_wb_no_bypass", 4'b0000, bm(9), 0, 0);
    wb_valid = 1'b0;
    cyc("blk_after_wb", 4'b1000, 32'h0, 0, 0);
    idle(); blk_done = 1'b1;
    cyc("blk_done2", 4'b0000, 32'h0, 0, 1);
    idle();
    cyc("run2", 4'b0000, 32'h0, 0, 0);

    // Blocking memory op drives both the FSM and mem_busy.
    req(0, 1, 1, 0, 0);
    cyc("blk_mem", 4'b0001, 32'h0, 0, 0);
    idle();
    cyc("blk_mem_state", 4'b0000, 32'h0, 1, 1);
    blk_done = 1'b1; mem_done = 1'b1;
    cyc("blk_mem_done", 4'b0000, 32'h0, 1, 1);
    idle();
    cyc("blk_mem_clear", 4'b0000, 32'h0, 0, 0);

    // Reset mid-operation discards lock, busy and pointer.
    req(1, 0, 1, 12, 0);
    cyc("pre_rst", 4'b0010, 32'h0, 0, 0);
    idle(); valid = 4'hF; rst_n = 1'b0;
    cyc("rst_mid", 4'b0000, bm(12), 1, 0);
    rst_n = 1'b1;
    cyc("post_rst_rr", 4'b0001, 32'h0, 0, 0);

    // Randomized run against a reference model, starting from a fresh reset.
    idle(); rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_locks = '0; m_busy = 1'b0; m_blk = 1'b0; m_rr = 0;
    for (int c = 0; c < 20000; c++) begin
      logic [3:0]  e;
      logic [3:0]  g;
      int          gi;
      int          base;
      logic [31:0] nl;
      exp_t        ex;
      for (int p = 0; p < NP; p++) begin
        int          r;
        logic [31:0] s;
        valid[p]    = ($urandom_range(0, 1) == 1);
        blocking[p] = ($urandom_range(0, 7) == 0);
        mem_op[p]   = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) r = 0;
        rd_bus[p*5 +: 5] = r[4:0];
        s = $urandom & $urandom & $urandom;
        src_bus[p*32 +: 32] = s;
      end
      wb_valid = ($urandom_range(0, 3) != 0);
      base = $urandom_range(0, 31);
      wb_rd = base[4:0];
      for (int k = 0; k < 32; k++) begin
        if (m_locks[(base + k) % 32] && (wb_rd == base[4:0])) wb_rd = 5'((base + k) % 32);
      end
      if ($urandom_range(0, 7) == 0) wb_rd = 5'd0;
      mem_done = ($urandom_range(0, 2) == 0);
      blk_done = ($urandom_range(0, 3) == 0);

      for (int p = 0; p < NP; p++) begin
        logic [4:0] prd;
        prd  = rd_bus[p*5 +: 5];
        e[p] = !m_blk && valid[p]
               && ((src_bus[p*32 +: 32] & m_locks & 32'hFFFF_FFFE) == 32'h0)
               && ((prd == 5'd0) || !m_locks[prd])
               && (!mem_op[p] || !m_busy)
               && (!blocking[p] || ((m_locks == 32'h0) && !m_busy));
      end
      g = '0; gi = -1;
      for (int i = 0; i < NP; i++) begin
        if (gi < 0 && e[(m_rr + i) % NP]) gi = (m_rr + i) % NP;
      end
      if (gi >= 0) g[gi] = 1'b1;

      ex.gnt = g; ex.locks = m_locks; ex.busy = m_busy; ex.blocked = m_blk;
      exp_q.push_back(ex);
      name_q.push_back("rand");

      nl = m_locks;
      if (wb_valid && wb_rd != 5'd0) nl[wb_rd] = 1'b0;
      if (gi >= 0) begin
        if (rd_bus[gi*5 +: 5] != 5'd0) nl[rd_bus[gi*5 +: 5]] = 1'b1;
        if (mem_op[gi]) m_busy = 1'b1;
        else if (mem_done) m_busy = 1'b0;
        if (!m_blk && blocking[gi]) m_blk = 1'b1;
        else if (m_blk && blk_done) m_blk = 1'b0;
        m_rr = (gi + 1) % NP;
      end else begin
        if (mem_done) m_busy = 1'b0;
        if (m_blk && blk_done) m_blk = 1'b0;
      end
      m_locks = nl;
      @(posedge clk); #1;
    end

    idle();
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
